// File: rtl/mc_control.sv
// Multi-cycle sequencing controller: steps fetch/decode/execute/memory/writeback
// over a shared variable-latency memory, with wait-timeout supervision and a sticky error state.
module mc_control #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [5:0]  BALRZ_FUNCT = 6'h16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       link,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       error,
  output logic [3:0] state
);

  localparam int unsigned CNT_W   = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_BALRZ  = 4'd10,
    S_ERROR  = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  logic             unused_zero;

  // zero is consumed by the datapath PC-load gating, not by the sequencer
  assign unused_zero = zero;
  assign state       = state_q;
  assign timed_out   = !mem_ready && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and Moore decode (FETCH load enables follow mem_ready)
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    link        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    error       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready)      state_d = S_DECODE;
        else if (timed_out) state_d = S_ERROR;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = (funct == BALRZ_FUNCT) ? S_BALRZ : S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else                                    state_d = S_ERROR;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready)      state_d = S_MEMWB;
        else if (timed_out) state_d = S_ERROR;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_ERROR;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_BALRZ: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        regdst      = 1'b1;
        regwrite    = 1'b1;
        link        = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b10;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_ERROR: error = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class, memory waits,
// illegal opcode, async reset out of ERROR and the wait-timeout boundary.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, link, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic       instr_done, error;
  logic [3:0] state;

  int unsigned total = 0;
  int unsigned fails = 0;

  // Field order: pw pwc iord mr mw irw rd m2r rw lk asa asb aop pcs done err
  localparam logic [18:0] C_RESET   = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] C_FETCH_R = 19'b1_0_0_1_0_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] C_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] C_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] C_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] C_MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] C_MEMWB   = 19'b0_0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [18:0] C_MEMWR_W = 19'b0_0_1_0_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] C_MEMWR_R = 19'b0_0_1_0_1_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [18:0] C_EXEC    = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] C_RWB     = 19'b0_0_0_0_0_0_1_0_1_0_0_00_00_00_1_0;
  localparam logic [18:0] C_BRANCH  = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [18:0] C_BALRZ   = 19'b0_1_0_0_0_0_1_0_1_1_1_00_01_10_1_0;
  localparam logic [18:0] C_ERROR   = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  logic [18:0] ctrl;
  assign ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdst, memtoreg,
                 regwrite, link, alusrca, alusrcb, aluop, pcsource, instr_done, error};

  mc_control #(.TIMEOUT(16), .BALRZ_FUNCT(6'h16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .link(link), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .instr_done(instr_done),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] es, input logic [18:0] ec);
    total++;
    assert ({state, ctrl} === {es, ec}) else begin
      fails++;
      $error("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b", tag, state, ctrl, es, ec);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #2 chk("reset_asserted", 4'd0, C_RESET);
    rst_n = 1'b1;
    #1 chk("reset_released", 4'd0, C_RESET);

    // R-type add, zero-wait: 1,2,7,8 then back to 1
    tick(); chk("r_fetch", 4'd1, C_FETCH_R);
    tick(); chk("r_decode", 4'd2, C_DECODE);
    tick(); chk("r_exec", 4'd7, C_EXEC);
    tick(); chk("r_rwb", 4'd8, C_RWB);
    opcode = 6'h23;
    tick(); chk("r_back_fetch", 4'd1, C_FETCH_R);

    // lw with three wait cycles in MEMRD
    tick(); chk("lw_decode", 4'd2, C_DECODE);
    mem_ready = 1'b0;
    tick(); chk("lw_memadr", 4'd3, C_MEMADR);
    tick(); chk("lw_memrd1", 4'd4, C_MEMRD);
    tick(); chk("lw_memrd2", 4'd4, C_MEMRD);
    tick(); chk("lw_memrd3", 4'd4, C_MEMRD);
    tick(); mem_ready = 1'b1; #1 chk("lw_memrd4", 4'd4, C_MEMRD);
    tick(); chk("lw_memwb", 4'd5, C_MEMWB);
    opcode = 6'h2B;
    tick(); chk("lw_back_fetch", 4'd1, C_FETCH_R);

    // sw with one wait cycle; instr_done follows mem_ready
    tick(); chk("sw_decode", 4'd2, C_DECODE);
    mem_ready = 1'b0;
    tick(); chk("sw_memadr", 4'd3, C_MEMADR);
    tick(); chk("sw_memwr_wait", 4'd6, C_MEMWR_W);
    tick(); chk("sw_memwr_wait2", 4'd6, C_MEMWR_W);
    mem_ready = 1'b1; #1 chk("sw_memwr_ready", 4'd6, C_MEMWR_R);
    opcode = 6'h04; zero = 1'b1;
    tick(); chk("sw_back_fetch", 4'd1, C_FETCH_R);

    // beq taken then not taken: controller outputs identical
    tick(); chk("beq1_decode", 4'd2, C_DECODE);
    tick(); chk("beq1_branch", 4'd9, C_BRANCH);
    zero = 1'b0;
    tick(); chk("beq1_fetch", 4'd1, C_FETCH_R);
    tick(); chk("beq2_decode", 4'd2, C_DECODE);
    tick(); chk("beq2_branch", 4'd9, C_BRANCH);
    opcode = 6'h00; funct = 6'h16; zero = 1'b1;
    tick(); chk("beq2_fetch", 4'd1, C_FETCH_R);

    // balrz
    tick(); chk("balrz_decode", 4'd2, C_DECODE);
    tick(); chk("balrz_exec", 4'd10, C_BALRZ);
    opcode = 6'h3F;
    tick(); chk("balrz_fetch", 4'd1, C_FETCH_R);

    // illegal opcode -> sticky ERROR, async reset clears it
    tick(); chk("ill_decode", 4'd2, C_DECODE);
    tick(); chk("ill_error", 4'd15, C_ERROR);
    tick(); chk("ill_error_held", 4'd15, C_ERROR);
    tick(); chk("ill_error_held2", 4'd15, C_ERROR);
    #2 rst_n = 1'b0;
    #1 chk("ill_async_reset", 4'd0, C_RESET);
    opcode = 6'h00; funct = 6'h20;
    #2 rst_n = 1'b1;
    tick(); chk("ill_restart_fetch", 4'd1, C_FETCH_R);

    // FETCH timeout: 16th edge with mem_ready low -> ERROR
    mem_ready = 1'b0;
    #1 chk("to_fetch_wait", 4'd1, C_FETCH_W);
    for (int i = 0; i < 15; i++) tick();
    chk("to_fetch_15", 4'd1, C_FETCH_W);
    tick(); chk("to_error_16", 4'd15, C_ERROR);

    // Same boundary, ready arrives on the 16th edge -> DECODE
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick(); chk("to2_fetch", 4'd1, C_FETCH_W);
    for (int i = 0; i < 15; i++) tick();
    chk("to2_fetch_15", 4'd1, C_FETCH_W);
    mem_ready = 1'b1;
    #1 chk("to2_fetch_ready", 4'd1, C_FETCH_R);
    tick(); chk("to2_decode", 4'd2, C_DECODE);

    // Reset in the middle of a memory wait abandons it with no enables asserted
    tick(); chk("mid_exec", 4'd7, C_EXEC);
    tick(); chk("mid_rwb", 4'd8, C_RWB);
    mem_ready = 1'b0;
    tick(); chk("mid_fetch_wait", 4'd1, C_FETCH_W);
    #2 rst_n = 1'b0;
    #1 chk("mid_async_reset", 4'd0, C_RESET);
    mem_ready = 1'b1;
    #1 chk("mid_reset_ready", 4'd0, C_RESET);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
